general_reg_file: RTL



---
 rtl/general_reg_file_pkg.sv | 18 +
 rtl/general_reg_file.sv | 103 ++++++++++
 2 files changed

// File: rtl/general_reg_file_pkg.sv
// Shared constants and FSM encodings for the general register file.
package general_reg_file_pkg;

  localparam int WordWidth = 32;
  localparam int GeneralRegAddrWidth = 5;
  localparam int GeneralRegNum = 32;

  localparam logic GeneralEnable = 1'b1;
  localparam logic GeneralDisable = 1'b0;

  localparam logic [WordWidth-1:0] ZeroWord = 32'h0;

  typedef enum logic {
    RegFileClear = 1'b0,
    RegFileRun   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/general_reg_file.sv
// Integer register file: two combinational read ports with write bypass,
// one write port, and a post-reset zero-fill sequencer gating ready.
module general_reg_file
  import general_reg_file_pkg::*;
#(
  parameter int RegNum = GeneralRegNum,
  localparam int AddrW = $clog2(RegNum)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AddrW-1:0]     readAddr1,
  input  logic [AddrW-1:0]     readAddr2,
  output logic [WordWidth-1:0] readData1,
  output logic [WordWidth-1:0] readData2,
  input  logic                 doWriteGeneralReg,
  input  logic [AddrW-1:0]     writeGeneralRegAddr,
  input  logic [WordWidth-1:0] writeGeneralRegData,
  output logic                 ready
);

  localparam logic [AddrW-1:0] LastIdx = AddrW'(RegNum - 1);

  rf_state_e state_q, state_d;
  logic [AddrW-1:0] clear_idx_q, clear_idx_d;
  logic ready_q, ready_d;

  logic [WordWidth-1:0] regs_q [RegNum];

  logic                 wr_en;
  logic [AddrW-1:0]     wr_addr;
  logic [WordWidth-1:0] wr_data;
  logic                 ext_wr;

  assign ext_wr = (doWriteGeneralReg == GeneralEnable)
               && (writeGeneralRegAddr != '0);

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    ready_d     = ready_q;
    wr_en       = 1'b0;
    wr_addr     = writeGeneralRegAddr;
    wr_data     = writeGeneralRegData;
    case (state_q)
      RegFileClear: begin
        wr_en   = !rst;
        wr_addr = clear_idx_q;
        wr_data = ZeroWord;
        if (clear_idx_q == LastIdx) begin
          state_d = RegFileRun;
          ready_d = 1'b1;
        end else begin
          clear_idx_d = clear_idx_q + 1'b1;
        end
      end
      RegFileRun: begin
        wr_en = !rst && ext_wr;
      end
      default: begin
        state_d = RegFileClear;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RegFileClear;
      clear_idx_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      ready_q     <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // x0 and the whole clear window read as zero; otherwise bypass wins.
  function automatic logic [WordWidth-1:0] rd_port(
    input logic [AddrW-1:0] addr
  );
    logic [WordWidth-1:0] val;
    val = ZeroWord;
    if (state_q == RegFileRun && addr != '0) begin
      if (ext_wr && writeGeneralRegAddr == addr) begin
        val = writeGeneralRegData;
      end else begin
        val = regs_q[addr];
      end
    end
    return val;
  endfunction

  assign readData1 = rd_port(readAddr1);
  assign readData2 = rd_port(readAddr2);
  assign ready     = ready_q;

endmodule
